matrix_scan_ctrl: RTL and testbench
===================================

// Module: matrix_scan_ctrl
// PURPOSE
//  Scan sequencer for the 8x16 dot-matrix display. Each row it fetches 16 column bits from a
//  double-buffered frame store over a req/ack handshake, blanks the display against ghosting,
//  then drives the row for a fixed dwell time. Rows scan 7 down to 0. Buffer swaps requested
//  by game logic take effect only at a frame boundary.
// PARAMETERS
//  DWELL_CYC  1000  clk cycles a row is lit (SHOW), must be >=1
//  BLANK_CYC  16    clk cycles all rows off before each SHOW, must be >=1
//  FETCH_TMO  64    clk cycles FETCH waits for fetch_ack before giving up
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  en          in   1   scan enable
//  swap_req    in   1   1-cycle pulse: back buffer complete, swap at next frame end
//  fetch_req   out  1   row-data request to frame store
//  fetch_row   out  3   row index requested, valid while fetch_req=1
//  fetch_buf   out  1   buffer requested (= active_buf), valid while fetch_req=1
//  fetch_ack   in   1   frame store: fetch_data valid this cycle
//  fetch_data  in   16  column bits for fetch_row, bit i = column i lit
//  row         out  8   active-low row select
//  col         out  16  active-high column drive
//  active_buf  out  1   buffer currently displayed
//  frame_done  out  1   1-cycle pulse after row 0 SHOW completes
//  swap_ack    out  1   1-cycle pulse when active_buf toggles
//  fetch_err   out  1   sticky: a fetch timed out. Cleared only by rst.
// BEHAVIOUR
//  Reset values: state=IDLE, idx=7, row=8'hFF, col=0, fetch_req=0, active_buf=0,
//   swap_pend=0, frame_done=0, swap_ack=0, fetch_err=0. All outputs are registered.
//  FSM states: IDLE, FETCH, BLANK, SHOW.
//  - IDLE: row=FF, col=0. Go to FETCH on the first cycle en=1.
//  - FETCH: fetch_req=1, fetch_row=idx, fetch_buf=active_buf.
//    - The cycle fetch_ack=1: latch fetch_data. fetch_req drops next cycle. Go to BLANK.
//    - After FETCH_TMO cycles with no ack: latch 16'h0, set fetch_err, go to BLANK.
//    - An ack arriving in the same cycle as timeout is treated as an ack.
//  - BLANK: row=FF, col=0 for exactly BLANK_CYC cycles, then go to SHOW.
//  - SHOW: row=~(1<<idx), col=latched data for exactly DWELL_CYC cycles. Then:
//    - idx>0: idx-=1, go to FETCH.
//    - idx==0: idx=7, pulse frame_done. If swap_pend: toggle active_buf, pulse swap_ack,
//      clear swap_pend (same cycle as frame_done). Go to FETCH.
//  Row period = fetch wait + BLANK_CYC + DWELL_CYC cycles. With an ack in the first FETCH
//   cycle, the period is 1+BLANK_CYC+DWELL_CYC.
//  swap_req sets swap_pend from any state. Further pulses while pending are absorbed
//   (one swap only). A swap_req coincident with the frame-end cycle is honoured at that end.
//  en=0 in any non-IDLE state: next cycle goes to IDLE, row=FF, col=0, fetch_req=0, idx=7.
//   A partial frame gives no frame_done. swap_pend and active_buf are kept.
//  A fetch_ack outside FETCH is ignored.
//  rst asserted mid-operation: all state returns to reset values immediately (async).
//   A pending swap is lost.
// STRUCTURE
//  raiden_pkg holds: scan_state_t enum, MATRIX_ROWS=8, MATRIX_COLS=16, ROW_OFF=8'hFF.
//  One sub-module, scan_timer: a loadable down-counter with load, value and zero flag.
//   A single instance is reused for the FETCH timeout and the BLANK and SHOW dwell times.
//   Its width is $clog2 of the maximum of the three parameters.
// TESTING (DWELL_CYC=4, BLANK_CYC=2, FETCH_TMO=5)
//  1. rst, en=1, frame store acks next cycle returning 16'h8001<<r for row r:
//     - row goes 7F,BF,...,FE. col matches per row. Each row lit exactly 4 cycles.
//     - row=FF for 2 cycles before each row. frame_done pulses once per 8 rows.
//  2. swap_req mid-frame, then a second swap_req:
//     - active_buf toggles exactly once, at the frame end, with swap_ack and frame_done
//       in the same cycle.
//     - fetch_buf of the next row-7 fetch equals the new buffer.
//  3. fetch_ack withheld on row 3:
//     - fetch_req stays high 5 cycles, then drops. Row 3 shows col=0. fetch_err=1.
//     - Scanning continues and fetch_err stays 1.
//  4. Frame store acks on its 3rd request cycle: fetch_req high exactly 3 cycles.
//     The row period for that row is 3+2+4=9.
//  5. en=0 during SHOW of row 5:
//     - next cycle row=FF, col=0, state IDLE, no frame_done.
//     - en=1 later: restarts at row 7 with the pending swap kept.
//  6. rst pulsed during BLANK with swap_pend=1: outputs go to reset values immediately,
//     active_buf=0, and swap is not applied after reset releases.

Source files
------------

// File: rtl/raiden_pkg.sv
// rtl/raiden_pkg.sv - shared types and constants for the dot-matrix scan sequencer
package raiden_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, BLANK, SHOW} scan_state_t;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 16;
  localparam logic [MATRIX_ROWS-1:0] ROW_OFF = 8'hFF;

  // Counter width able to hold (largest duration - 1); never narrower than one bit.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - loadable down-counter that parks at zero and flags it
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// rtl/matrix_scan_ctrl.sv - 8x16 dot-matrix row scanner with fetch, blank and dwell phases
module matrix_scan_ctrl
  import raiden_pkg::*;
#(
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 16,
  parameter int FETCH_TMO = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           swap_req,
  output logic                           fetch_req,
  output logic [$clog2(MATRIX_ROWS)-1:0] fetch_row,
  output logic                           fetch_buf,
  input  logic                           fetch_ack,
  input  logic [MATRIX_COLS-1:0]         fetch_data,
  output logic [MATRIX_ROWS-1:0]         row,
  output logic [MATRIX_COLS-1:0]         col,
  output logic                           active_buf,
  output logic                           frame_done,
  output logic                           swap_ack,
  output logic                           fetch_err
);

  localparam int TW = timer_width(DWELL_CYC, BLANK_CYC, FETCH_TMO);
  localparam int IW = $clog2(MATRIX_ROWS);
  localparam logic [TW-1:0] TMO_LD   = TW'(FETCH_TMO - 1);
  localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYC - 1);
  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYC - 1);
  localparam logic [IW-1:0] TOP_ROW  = IW'(MATRIX_ROWS - 1);

  scan_state_t            state;
  logic [IW-1:0]          idx;
  logic [MATRIX_COLS-1:0] data_q;
  logic                   swap_pend;
  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic [TW-1:0]          tmr_value;
  logic                   tmr_zero;

  scan_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // The timer is reloaded on the same edge the FSM enters a timed phase,
  // so its zero flag lines up with the last cycle of that phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (en) begin
      case (state)
        IDLE: begin
          tmr_load = 1'b1;
          tmr_val  = TMO_LD;
        end
        FETCH: if (fetch_ack || tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = BLANK_LD;
        end
        BLANK: if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = DWELL_LD;
        end
        SHOW: if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TMO_LD;
        end
        default: ;
      endcase
    end
  end

  assign fetch_row = idx;
  assign fetch_buf = active_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= TOP_ROW;
      row        <= ROW_OFF;
      col        <= '0;
      data_q     <= '0;
      fetch_req  <= 1'b0;
      active_buf <= 1'b0;
      swap_pend  <= 1'b0;
      frame_done <= 1'b0;
      swap_ack   <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      swap_ack   <= 1'b0;
      swap_pend  <= swap_pend | swap_req;
      if (state != IDLE && !en) begin
        state     <= IDLE;
        row       <= ROW_OFF;
        col       <= '0;
        fetch_req <= 1'b0;
        idx       <= TOP_ROW;
      end else begin
        case (state)
          IDLE: if (en) begin
            state     <= FETCH;
            fetch_req <= 1'b1;
          end
          FETCH: if (fetch_ack) begin
            data_q    <= fetch_data;
            fetch_req <= 1'b0;
            state     <= BLANK;
          end else if (tmr_zero) begin
            data_q    <= '0;
            fetch_err <= 1'b1;
            fetch_req <= 1'b0;
            state     <= BLANK;
          end
          BLANK: if (tmr_zero) begin
            row   <= ~(MATRIX_ROWS'(1) << idx);
            col   <= data_q;
            state <= SHOW;
          end
          SHOW: if (tmr_zero) begin
            row       <= ROW_OFF;
            col       <= '0;
            fetch_req <= 1'b1;
            state     <= FETCH;
            if (idx == '0) begin
              // Frame boundary: the only point where the displayed buffer may change.
              idx        <= TOP_ROW;
              frame_done <= 1'b1;
              if (swap_pend || swap_req) begin
                active_buf <= ~active_buf;
                swap_ack   <= 1'b1;
                swap_pend  <= 1'b0;
              end
            end else begin
              idx <= idx - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb/tb_matrix_scan_ctrl.sv - randomized bench with a phase-timeline reference model
module tb_matrix_scan_ctrl;

  localparam int DW  = 4;
  localparam int BL  = 2;
  localparam int TMO = 5;

  logic        clk = 1'b0;
  logic        rst, en, swap_req, fetch_ack;
  logic [15:0] fetch_data;
  logic        fetch_req, fetch_buf, active_buf, frame_done, swap_ack, fetch_err;
  logic [2:0]  fetch_row;
  logic [7:0]  row;
  logic [15:0] col;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(.DWELL_CYC(DW), .BLANK_CYC(BL), .FETCH_TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .swap_req   (swap_req),
    .fetch_req  (fetch_req),
    .fetch_row  (fetch_row),
    .fetch_buf  (fetch_buf),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data),
    .row        (row),
    .col        (col),
    .active_buf (active_buf),
    .frame_done (frame_done),
    .swap_ack   (swap_ack),
    .fetch_err  (fetch_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  logic [15:0] mem [2][8];

  // Reference: phase 0 idle, 1 fetch, 2 blank, 3 show; m_k counts cycles spent in the phase.
  int          m_ph, m_r, m_k, m_lat;
  logic [15:0] m_data;
  logic        m_buf, m_pend, m_err, m_fd, m_sa;

  logic rst_v, en_v, swap_v;
  bit   rnd_mode;
  int   lat_cfg, ov_row, ov_lat;
  int   fd_cnt, sa_cnt, req_run, last_req_run, lit_run, ff_run;
  bit   chk_dwell;

  task automatic model_reset;
    m_ph = 0; m_r = 7; m_k = 0; m_lat = 1; m_data = '0;
    m_buf = 1'b0; m_pend = 1'b0; m_err = 1'b0; m_fd = 1'b0; m_sa = 1'b0;
  endtask

  function automatic int pick_lat(input int r);
    if (r == ov_row) return ov_lat;
    if (rnd_mode) return int'($urandom_range(1, 7));
    return lat_cfg;
  endfunction

  task automatic enter_fetch;
    m_ph = 1; m_k = 0; m_lat = pick_lat(m_r);
  endtask

  task automatic model_step(input logic ack, input logic [15:0] d);
    m_fd = 1'b0; m_sa = 1'b0;
    m_pend = m_pend | swap_req;
    if (m_ph != 0 && !en) begin
      m_ph = 0; m_r = 7; m_k = 0;
    end else begin
      case (m_ph)
        0: if (en) enter_fetch();
        1: begin
          m_k++;
          if (ack) begin m_data = d; m_ph = 2; m_k = 0; end
          else if (m_k == TMO) begin m_data = '0; m_err = 1'b1; m_ph = 2; m_k = 0; end
        end
        2: begin
          m_k++;
          if (m_k == BL) begin m_ph = 3; m_k = 0; end
        end
        default: begin
          m_k++;
          if (m_k == DW) begin
            if (m_r > 0) m_r--;
            else begin
              m_r = 7; m_fd = 1'b1;
              if (m_pend) begin m_buf = ~m_buf; m_sa = 1'b1; m_pend = 1'b0; end
            end
            enter_fetch();
          end
        end
      endcase
    end
  endtask

  task automatic step;
    logic [7:0]  er;
    logic [15:0] ec, d;
    logic        ack, rst_was;
    @(negedge clk);
    er = 8'hFF; ec = '0;
    if (m_ph == 3) begin er = ~(8'h01 << m_r); ec = m_data; end
    check("row", 32'(row), 32'(er));
    check("col", 32'(col), 32'(ec));
    check("fetch_req", 32'(fetch_req), 32'(m_ph == 1));
    if (m_ph == 1) begin
      check("fetch_row", 32'(fetch_row), 32'(m_r));
      check("fetch_buf", 32'(fetch_buf), 32'(m_buf));
    end
    check("active_buf", 32'(active_buf), 32'(m_buf));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("swap_ack", 32'(swap_ack), 32'(m_sa));
    check("fetch_err", 32'(fetch_err), 32'(m_err));
    if (frame_done === 1'b1) fd_cnt++;
    if (swap_ack === 1'b1) sa_cnt++;
    if (fetch_req === 1'b1) req_run++;
    else begin if (req_run > 0) last_req_run = req_run; req_run = 0; end
    if (row !== 8'hFF) begin
      if (lit_run == 0 && chk_dwell) check("blank_before_row", 32'(ff_run >= BL), 32'd1);
      lit_run++; ff_run = 0;
    end else begin
      if (lit_run > 0 && chk_dwell) check("dwell_len", 32'(lit_run), 32'(DW));
      lit_run = 0; ff_run++;
    end
    rst_was = rst;
    rst = rst_v; en = en_v; swap_req = swap_v; swap_v = 1'b0;
    ack = 1'b0; d = 16'($urandom);
    if (m_ph == 1 && m_lat != 0 && m_k + 1 == m_lat) begin ack = 1'b1; d = mem[m_buf][m_r]; end
    else if (rnd_mode && m_ph != 1 && $urandom_range(0, 3) == 0) ack = 1'b1;
    fetch_ack = ack; fetch_data = d;
    if (rst && !rst_was) begin
      #1;
      check("rst_async_row", 32'(row), 32'hFF);
      check("rst_async_buf", 32'(active_buf), 32'd0);
      check("rst_async_req", 32'(fetch_req), 32'd0);
    end
    if (rst_v) model_reset();
    else model_step(ack, d);
  endtask

  task automatic wait_model(input int ph, input int r, input string name);
    int n = 0;
    while (!(m_ph == ph && (r < 0 || m_r == r)) && n < 300) begin step(); n++; end
    check(name, 32'(m_ph == ph && (r < 0 || m_r == r)), 32'd1);
  endtask

  task automatic wait_swap_ack(input string name);
    int n = 0;
    do begin step(); n++; end while (swap_ack !== 1'b1 && n < 120);
    check(name, 32'(swap_ack), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 8; r++) begin
      mem[0][r] = 16'h8001 << r;
      mem[1][r] = 16'($urandom);
    end
    rst = 1'b1; en = 1'b0; swap_req = 1'b0; fetch_ack = 1'b0; fetch_data = '0;
    rst_v = 1'b1; en_v = 1'b0; swap_v = 1'b0;
    rnd_mode = 0; lat_cfg = 1; ov_row = -1; ov_lat = 0; chk_dwell = 0;
    fd_cnt = 0; sa_cnt = 0; req_run = 0; last_req_run = 0; lit_run = 0; ff_run = 0;
    model_reset();
    repeat (2) step();
    check("reset_row", 32'(row), 32'hFF);
    check("reset_col", 32'(col), 32'd0);
    check("reset_req", 32'(fetch_req), 32'd0);
    check("reset_err", 32'(fetch_err), 32'd0);

    // Immediate acks: two full frames of 8 rows x (1+2+4) cycles.
    rst_v = 1'b0; en_v = 1'b1; chk_dwell = 1;
    repeat (120) step();
    check("t1_frames", 32'(fd_cnt), 32'd2);
    chk_dwell = 0;

    // Two swap requests mid-frame collapse into one swap at the frame end.
    sa_cnt = 0;
    repeat (20) step();
    swap_v = 1'b1; step();
    repeat (10) step();
    swap_v = 1'b1; step();
    wait_swap_ack("t2_swap_seen");
    check("t2_active_buf", 32'(active_buf), 32'd1);
    check("t2_frame_done", 32'(frame_done), 32'd1);
    check("t2_fetch_buf", 32'(fetch_buf), 32'd1);
    repeat (60) step();
    check("t2_swap_count", 32'(sa_cnt), 32'd1);

    // Row 3 never acknowledged: timeout after 5 request cycles.
    ov_row = 3; ov_lat = 0;
    wait_model(1, 3, "t3_reach_row3");
    ov_row = -1;
    repeat (9) step();
    check("t3_req_len", 32'(last_req_run), 32'd5);
    check("t3_row", 32'(row), 32'hF7);
    check("t3_col", 32'(col), 32'd0);
    check("t3_err", 32'(fetch_err), 32'd1);
    repeat (60) step();
    check("t3_err_sticky", 32'(fetch_err), 32'd1);

    // Ack on the third request cycle: row period 3+2+4.
    ov_row = 6; ov_lat = 3;
    wait_model(1, 6, "t4_reach_row6");
    ov_row = -1;
    repeat (9) step();
    check("t4_row_last", 32'(row), 32'hBF);
    step();
    check("t4_next_fetch", 32'(fetch_req && fetch_row == 3'd5), 32'd1);
    check("t4_req_len", 32'(last_req_run), 32'd3);

    // Scan disabled during row 5 SHOW with a swap pending.
    wait_model(3, 5, "t5_reach_show5");
    swap_v = 1'b1; step();
    en_v = 1'b0; step();
    step();
    check("t5_idle_row", 32'(row), 32'hFF);
    check("t5_idle_col", 32'(col), 32'd0);
    fd_cnt = 0;
    repeat (10) step();
    check("t5_no_frame_done", 32'(fd_cnt), 32'd0);
    sa_cnt = 0; en_v = 1'b1;
    step(); step();
    check("t5_restart_row7", 32'(fetch_req && fetch_row == 3'd7), 32'd1);
    repeat (60) step();
    check("t5_swap_kept", 32'(sa_cnt), 32'd1);
    check("t5_active_buf", 32'(active_buf), 32'd0);

    // Reset during BLANK loses the pending swap.
    swap_v = 1'b1; step();
    wait_swap_ack("t6_pre_swap");
    check("t6_pre_buf", 32'(active_buf), 32'd1);
    swap_v = 1'b1; step();
    wait_model(2, -1, "t6_reach_blank");
    rst_v = 1'b1; step(); step();
    rst_v = 1'b0; sa_cnt = 0;
    repeat (70) step();
    check("t6_no_swap", 32'(sa_cnt), 32'd0);
    check("t6_active_buf", 32'(active_buf), 32'd0);

    // Randomized traffic: ack latency, spurious acks, swaps, enable drops, resets.
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      swap_v = ($urandom_range(0, 29) == 0);
      en_v   = ($urandom_range(0, 99) != 0);
      rst_v  = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 15) == 0) mem[$urandom_range(0, 1)][$urandom_range(0, 7)] = 16'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
